// File: rtl/byte_rr_arbiter.sv
// Round-robin arbiter and capture stage for a 4:1 byte mux. It drives the mux select,
// latches the returned byte, acks the requester and offers the byte on a valid/ready port.
module byte_rr_arbiter (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] req,
    input  logic [7:0] mux_dout,
    input  logic       out_ready,
    output logic [1:0] select,
    output logic [3:0] ack,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic [7:0] xfer_count
);

    typedef enum logic [1:0] {StIdle, StCapture, StOutput} state_e;

    state_e     state_q, state_d;
    logic [1:0] select_q, select_d;
    logic [1:0] last_q, last_d;
    logic [3:0] ack_q, ack_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [7:0] count_q, count_d;

    logic [1:0] grant;
    logic       found;

    // Scan from the requester after the last one served, wrapping mod 4.
    always_comb begin
        grant = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && req[last_q + 2'(k)]) begin
                grant = last_q + 2'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        last_d   = last_q;
        ack_d    = 4'b0000;
        data_d   = data_q;
        valid_d  = valid_q;
        count_d  = count_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    select_d = grant;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                // req is not re-checked; the requester holds its byte until ack.
                data_d  = mux_dout;
                valid_d = 1'b1;
                ack_d   = 4'b0001 << select_q;
                state_d = StOutput;
            end
            StOutput: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    last_d  = select_q;
                    count_d = count_q + 8'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            select_q <= 2'd0;
            last_q   <= 2'd3;
            ack_q    <= 4'b0000;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign select     = select_q;
    assign ack        = ack_q;
    assign data_out   = data_q;
    assign out_valid  = valid_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_byte_rr_arbiter.sv
// Bench for byte_rr_arbiter: a small mux model, a vector table for arbitration order and
// hand sequences for backpressure, mid-flight reset and counter wrap.
module tb_byte_rr_arbiter;

    logic       Clk;
    logic       Reset;
    logic [3:0] req;
    logic [7:0] mux_dout;
    logic       out_ready;
    logic [1:0] select;
    logic [3:0] ack;
    logic [7:0] data_out;
    logic       out_valid;
    logic [7:0] xfer_count;

    logic [7:0] mux_in [4];
    assign mux_dout = mux_in[select];

    byte_rr_arbiter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .mux_dout  (mux_dout),
        .out_ready (out_ready),
        .select    (select),
        .ack       (ack),
        .data_out  (data_out),
        .out_valid (out_valid),
        .xfer_count(xfer_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        logic [3:0] req;
        logic [1:0] exp_sel;
        logic [7:0] exp_data;
        logic [7:0] exp_count;
    } vec_t;

    sb_t  sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_pulses = 0;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Handshake monitor: pops the scoreboard when the DUT hands a byte downstream.
    always @(posedge Clk) begin
        if (!Reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_xfer", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_select", 32'(select), 32'(e.sel));
                check("sb_data", 32'(data_out), 32'(e.data));
            end
        end
        if (!Reset && ack != 4'b0000) ack_pulses++;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_select"}, 32'(select), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'h00);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_count"}, 32'(xfer_count), 32'd0);
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        req   = 4'b0000;
        step();
        check_reset_vals("rst");
        Reset = 1'b0;
        sb.delete();
    endtask

    // One full transfer with out_ready high: IDLE -> CAPTURE -> OUTPUT -> IDLE.
    task automatic do_xfer(input logic [3:0] r, input logic [1:0] es, input logic [7:0] ed,
                           input logic [7:0] ec, input bit hold);
        sb_t e;
        out_ready = 1'b1;
        req = r;
        e.sel = es;
        e.data = ed;
        sb.push_back(e);
        step();
        check("x_select", 32'(select), 32'(es));
        check("x_valid_lo", 32'(out_valid), 32'd0);
        step();
        check("x_data", 32'(data_out), 32'(ed));
        check("x_valid_hi", 32'(out_valid), 32'd1);
        check("x_ack", 32'(ack), 32'(4'b0001 << es));
        if (!hold) req = 4'b0000;
        step();
        check("x_valid_clr", 32'(out_valid), 32'd0);
        check("x_ack_clr", 32'(ack), 32'd0);
        check("x_count", 32'(xfer_count), 32'(ec));
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        req = 4'b0000;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) mux_in[i] = 8'h10 + 8'(i);

        vecs[0] = '{4'b1111, 2'd0, 8'h10, 8'd1};
        vecs[1] = '{4'b1111, 2'd1, 8'h11, 8'd2};
        vecs[2] = '{4'b1111, 2'd2, 8'h12, 8'd3};
        vecs[3] = '{4'b1111, 2'd3, 8'h13, 8'd4};
        vecs[4] = '{4'b1111, 2'd0, 8'h10, 8'd5};
        vecs[5] = '{4'b1001, 2'd3, 8'h13, 8'd6};
        vecs[6] = '{4'b0110, 2'd1, 8'h11, 8'd7};
        vecs[7] = '{4'b0011, 2'd0, 8'h10, 8'd8};
        vecs[8] = '{4'b0001, 2'd0, 8'h10, 8'd9};
        vecs[9] = '{4'b1100, 2'd2, 8'h12, 8'd10};

        step();
        apply_reset();

        // Idle with no requests.
        for (int c = 0; c < 10; c++) begin
            step();
            check_reset_vals("idle");
        end

        // Single request from requester 2.
        mux_in[2] = 8'hA5;
        do_xfer(4'b0100, 2'd2, 8'hA5, 8'd1, 1'b0);
        mux_in[2] = 8'h12;

        // Arbitration order table.
        apply_reset();
        for (int v = 0; v < 10; v++)
            do_xfer(vecs[v].req, vecs[v].exp_sel, vecs[v].exp_data, vecs[v].exp_count, 1'b1);
        req = 4'b0000;

        // Backpressure: last = 2, so requester 1 alone is granted.
        mux_in[1] = 8'h3C;
        out_ready = 1'b0;
        ack_pulses = 0;
        req = 4'b0010;
        begin
            sb_t e;
            e.sel = 2'd1;
            e.data = 8'h3C;
            sb.push_back(e);
        end
        step();
        check("bp_select", 32'(select), 32'd1);
        step();
        check("bp_ack", 32'(ack), 32'b0010);
        req = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            check("bp_data_hold", 32'(data_out), 32'h3C);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_select_hold", 32'(select), 32'd1);
            check("bp_count_hold", 32'(xfer_count), 32'd10);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_valid_clr", 32'(out_valid), 32'd0);
        check("bp_count", 32'(xfer_count), 32'd11);
        check("bp_ack_once", 32'(ack_pulses), 32'd1);
        mux_in[1] = 8'h11;

        // Reset in CAPTURE: last = 1, requester 2 granted, then abandoned.
        ack_pulses = 0;
        req = 4'b0100;
        step();
        check("rc_select", 32'(select), 32'd2);
        Reset = 1'b1;
        req = 4'b0000;
        step();
        check_reset_vals("rc");
        Reset = 1'b0;
        step();
        check("rc_no_ack", 32'(ack_pulses), 32'd0);
        check("rc_count", 32'(xfer_count), 32'd0);
        do_xfer(4'b1000, 2'd3, 8'h13, 8'd1, 1'b0);

        // Reset in OUTPUT with out_ready low: last = 3, requester 1 granted.
        out_ready = 1'b0;
        req = 4'b0010;
        step();
        check("ro_select", 32'(select), 32'd1);
        step();
        check("ro_valid", 32'(out_valid), 32'd1);
        req = 4'b0000;
        step();
        check("ro_hold", 32'(out_valid), 32'd1);
        Reset = 1'b1;
        step();
        check_reset_vals("ro");
        Reset = 1'b0;
        sb.delete();
        do_xfer(4'b1000, 2'd3, 8'h13, 8'd1, 1'b0);

        // Counter wrap over 256 transfers.
        apply_reset();
        for (int t = 0; t < 256; t++) begin
            logic [1:0] es;
            es = 2'(t % 4);
            do_xfer(4'b1111, es, 8'h10 + 8'(es), 8'(t + 1), 1'b1);
            if (t == 254) check("wrap_255", 32'(xfer_count), 32'd255);
            if (t == 255) check("wrap_0", 32'(xfer_count), 32'd0);
        end
        req = 4'b0000;
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_rr_arbiter.md
# byte_rr_arbiter

Round-robin arbiter and capture stage that sits directly upstream of the 4:1 8-bit byte multiplexer. It drives the multiplexer's 2-bit select and registers the multiplexer's output. Up to four requesters each present a byte on one multiplexer input and raise a request. The block grants one requester at a time, latches the selected byte, acknowledges the granted requester, and offers the byte downstream with a valid/ready handshake.

## Interface
- No parameters. The data width is fixed at 8 and the requester count at 4.
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; req[i] means requester i is presenting a byte on mux input i.
- mux_dout  input  8  byte returned from the multiplexer output.
- out_ready  input  1  downstream can accept data_out this cycle.
- select  output  2  registered select driven to the multiplexer.
- ack  output  4  one-hot, one-cycle pulse to the granted requester when its byte has been latched.
- data_out  output  8  registered captured byte.
- out_valid  output  1  data_out holds a byte not yet accepted downstream.
- xfer_count  output  8  count of completed transfers; wraps 255 -> 0.

## Operation
- There are three FSM states: IDLE, CAPTURE, and OUTPUT. The reset state is IDLE.
- Reset values:
  - select = 0, data_out = 0x00, out_valid = 0, ack = 0000, xfer_count = 0.
  - Internal last-grant pointer = 3, so requester 0 has highest priority first.
- IDLE:
  - If req == 0, stay in IDLE. Outputs are held.
  - Otherwise, scan starting at (last+1) mod 4, incrementing mod 4. The first i with req[i] = 1 wins.
  - Set select <= i and move to CAPTURE.
- CAPTURE:
  - Set data_out <= mux_dout, out_valid <= 1, ack <= one-hot(select). Move to OUTPUT.
  - req is not re-checked here. Requesters must hold req and their byte stable until ack.
- OUTPUT:
  - ack <= 0000 on the first edge in this state, so ack is high for exactly one cycle.
  - If out_valid && out_ready: out_valid <= 0, last <= select, xfer_count <= xfer_count + 1 (mod 256), and move to IDLE.
  - Otherwise hold. data_out, select, and out_valid stay stable while out_ready = 0.
- Requester contract: drop req[i] on the edge after seeing ack[i]. A still-high req[i] in IDLE is treated as a new request.
- select changes only on the IDLE -> CAPTURE edge. data_out changes only on the CAPTURE -> OUTPUT edge or on reset.
- Reset asserted in any state:
  - Return to IDLE with all reset values on that edge.
  - An in-flight grant is abandoned: no ack and no count increment.
- Reset has priority over every other event on the same edge.

## Timing
- Request sampled in IDLE at edge k:
  - select is valid after edge k.
  - data_out, out_valid, and ack are valid after edge k+1.
- Minimum transfer period is 3 cycles (IDLE, CAPTURE, OUTPUT), with out_ready = 1 in the OUTPUT cycle.
- The multiplexer path is combinational. select is registered one full cycle before mux_dout is sampled, so the path through the multiplexer is a single-cycle path.
- out_valid rises and falls only on clock edges. out_ready is sampled only in OUTPUT.
- Back-to-back operation: with every req held high and out_ready = 1, grants rotate 0,1,2,3,0,… with one grant every 3 cycles.
- xfer_count increments on the same edge that out_valid falls.

## Test plan
- Reset, then req = 0000 for 10 cycles -> select = 0, out_valid = 0, ack = 0000, xfer_count = 0 throughout.
- Single request: req = 0100 with mux_dout = 0xA5 while select = 2, out_ready = 1, requester drops req on ack.
  - select = 2 one edge later.
  - The next edge gives data_out = 0xA5, out_valid = 1, and ack = 0100 for one cycle.
  - out_valid clears the following edge and xfer_count = 1.
- Round-robin fairness: req = 1111 held, out_ready = 1, input i presents byte 0x10+i.
  - Grant order is 0,1,2,3,0.
  - data_out sequence is 0x10, 0x11, 0x12, 0x13, 0x10.
  - xfer_count = 5 after the fifth handshake.
- Backpressure: grant requester 1 with byte 0x3C, out_ready = 0 for 6 cycles, then 1.
  - data_out = 0x3C, out_valid = 1, and select = 1 stay stable.
  - ack pulses exactly once.
  - One count increment occurs only on the ready edge.
- Reset mid-operation: assert Reset in the CAPTURE state, and separately in the OUTPUT state with out_ready = 0.
  - Each case returns to the reset values on the next edge.
  - A CAPTURE-state reset produces no ack.
  - xfer_count does not change.
  - After reset release with req = 1000, requester 3 is granted.
- Counter wrap: complete 256 transfers -> xfer_count reads 255 after transfer 255 and 0 after transfer 256.
